// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count, almost-full/empty
// thresholds and registered overflow/underflow pulses for rejected requests.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w,
  input  logic                    r,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   CNT_AE   = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok, wr_ok;
  logic                  empty_s, full_s;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == CNT_FULL);

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_ok = r && !empty_s;
  assign wr_ok = w && (!full_s || rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = w && !wr_ok;
    underflow_d = r && !rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately unreset; reset only clears pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a default-threshold instance and a 12/3
// threshold instance driven by the same stimulus.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w   = 1'b0;
  logic        r   = 1'b0;
  logic [15:0] data_in = '0;

  logic [15:0] d_dout, t_dout;
  logic        d_empty, d_full, d_af, d_ae, d_ov, d_un;
  logic        t_empty, t_full, t_af, t_ae, t_ov, t_un;
  logic [4:0]  d_count, t_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(16), .DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .w(w), .r(r), .data_in(data_in),
    .data_out(d_dout), .empty(d_empty), .full(d_full),
    .almost_full(d_af), .almost_empty(d_ae), .count(d_count),
    .overflow(d_ov), .underflow(d_un)
  );

  sync_fifo #(.DATA_WIDTH(16), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(3)) u_thr (
    .clk(clk), .rst(rst), .w(w), .r(r), .data_in(data_in),
    .data_out(t_dout), .empty(t_empty), .full(t_full),
    .almost_full(t_af), .almost_empty(t_ae), .count(t_count),
    .overflow(t_ov), .underflow(t_un)
  );

  task automatic cycle(input logic wi, input logic ri, input logic [15:0] di);
    w = wi; r = ri; data_in = di;
    @(posedge clk); #1;
    w = 1'b0; r = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (d_count !== 5'd0 || d_empty !== 1'b1 || d_full !== 1'b0 || d_af !== 1'b0 ||
        d_ae !== 1'b1 || d_dout !== 16'h0000 || d_ov !== 1'b0 || d_un !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d empty=%b full=%b af=%b ae=%b dout=%h ov=%b un=%b, want 0 1 0 0 1 0000 0 0",
               d_count, d_empty, d_full, d_af, d_ae, d_dout, d_ov, d_un);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 16'(i));
      checks++;
      if (d_count !== 5'(i) || d_full !== (i == 16) || d_af !== (i >= 14) ||
          d_empty !== 1'b0 || d_ov !== 1'b0) begin
        errors++;
        $display("FAIL fill[%0d]: count=%0d full=%b af=%b empty=%b ov=%b, want %0d %b %b 0 0",
                 i, d_count, d_full, d_af, d_empty, d_ov, i, (i == 16), (i >= 14));
      end
      checks++;
      if (t_af !== (i >= 12) || t_ae !== (i <= 3)) begin
        errors++;
        $display("FAIL thr_fill[%0d]: af=%b ae=%b, want %b %b", i, t_af, t_ae, (i >= 12), (i <= 3));
      end
    end
    cycle(1'b1, 1'b0, 16'hDEAD);
    checks++;
    if (d_ov !== 1'b1 || d_count !== 5'd16 || d_full !== 1'b1) begin
      errors++;
      $display("FAIL overflow: ov=%b count=%0d full=%b, want 1 16 1", d_ov, d_count, d_full);
    end
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (d_ov !== 1'b0 || d_count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_pulse: ov=%b count=%0d, want 0 16", d_ov, d_count);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 16'h0000);
      checks++;
      if (d_dout !== 16'(i) || d_count !== 5'(16 - i) || d_empty !== (i == 16) || d_un !== 1'b0) begin
        errors++;
        $display("FAIL drain[%0d]: dout=%h count=%0d empty=%b un=%b, want %h %0d %b 0",
                 i, d_dout, d_count, d_empty, d_un, 16'(i), 16 - i, (i == 16));
      end
      checks++;
      if (t_af !== ((16 - i) >= 12) || t_ae !== ((16 - i) <= 3)) begin
        errors++;
        $display("FAIL thr_drain[%0d]: af=%b ae=%b, want %b %b",
                 i, t_af, t_ae, ((16 - i) >= 12), ((16 - i) <= 3));
      end
    end
    cycle(1'b0, 1'b1, 16'h0000);
    checks++;
    if (d_un !== 1'b1 || d_dout !== 16'h0010 || d_count !== 5'd0) begin
      errors++;
      $display("FAIL underflow: un=%b dout=%h count=%0d, want 1 0010 0", d_un, d_dout, d_count);
    end
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (d_un !== 1'b0 || d_dout !== 16'h0010) begin
      errors++;
      $display("FAIL underflow_pulse: un=%b dout=%h, want 0 0010", d_un, d_dout);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 16'h0000);
      checks++;
      if (d_dout !== 16'h0100 + 16'(i)) begin
        errors++;
        $display("FAIL wrap_a[%0d]: dout=%h, want %h", i, d_dout, 16'h0100 + 16'(i));
      end
    end
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'h0200 + 16'(i));
    checks++;
    if (d_full !== 1'b1 || d_count !== 5'd16) begin
      errors++;
      $display("FAIL wrap_full: full=%b count=%0d, want 1 16", d_full, d_count);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 16'h0000);
      checks++;
      if (d_dout !== 16'h0200 + 16'(i)) begin
        errors++;
        $display("FAIL wrap_b[%0d]: dout=%h, want %h", i, d_dout, 16'h0200 + 16'(i));
      end
    end
    checks++;
    if (d_count !== 5'd0 || d_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end: count=%0d empty=%b, want 0 1", d_count, d_empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'h0300 + 16'(i));
    cycle(1'b1, 1'b1, 16'hAAAA);
    checks++;
    if (d_count !== 5'd16 || d_full !== 1'b1 || d_dout !== 16'h0300 || d_ov !== 1'b0 || d_un !== 1'b0) begin
      errors++;
      $display("FAIL full_wr: count=%0d full=%b dout=%h ov=%b un=%b, want 16 1 0300 0 0",
               d_count, d_full, d_dout, d_ov, d_un);
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 16'h0000);
      checks++;
      if (d_dout !== ((i == 16) ? 16'hAAAA : 16'h0300 + 16'(i))) begin
        errors++;
        $display("FAIL full_wr_drain[%0d]: dout=%h, want %h",
                 i, d_dout, ((i == 16) ? 16'hAAAA : 16'h0300 + 16'(i)));
      end
    end
    cycle(1'b1, 1'b1, 16'h5555);
    checks++;
    if (d_count !== 5'd1 || d_un !== 1'b1 || d_ov !== 1'b0 || d_dout !== 16'hAAAA || d_empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_wr: count=%0d un=%b ov=%b dout=%h empty=%b, want 1 1 0 aaaa 0",
               d_count, d_un, d_ov, d_dout, d_empty);
    end
    cycle(1'b0, 1'b1, 16'h0000);
    checks++;
    if (d_dout !== 16'h5555 || d_count !== 5'd0 || d_un !== 1'b0) begin
      errors++;
      $display("FAIL empty_wr_read: dout=%h count=%0d un=%b, want 5555 0 0", d_dout, d_count, d_un);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'h0400 + 16'(i));
    cycle(1'b0, 1'b1, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0407);
    checks++;
    if (d_count !== 5'd7 || d_dout !== 16'h0400) begin
      errors++;
      $display("FAIL pre_reset: count=%0d dout=%h, want 7 0400", d_count, d_dout);
    end
    rst = 1'b1; w = 1'b1; r = 1'b1; data_in = 16'hBEEF;
    @(posedge clk); #1;
    rst = 1'b0; w = 1'b0; r = 1'b0;
    checks++;
    if (d_count !== 5'd0 || d_empty !== 1'b1 || d_dout !== 16'h0000 || d_ov !== 1'b0 || d_un !== 1'b0 ||
        t_count !== 5'd0 || t_ae !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b dout=%h ov=%b un=%b tcount=%0d tae=%b, want 0 1 0000 0 0 0 1",
               d_count, d_empty, d_dout, d_ov, d_un, t_count, t_ae);
    end
    cycle(1'b0, 1'b1, 16'h0000);
    checks++;
    if (d_un !== 1'b1 || d_dout !== 16'h0000 || d_count !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_read: un=%b dout=%h count=%0d, want 1 0000 0", d_un, d_dout, d_count);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
